// File: rtl/ins_dispatch.sv
// rtl/ins_dispatch.sv - instruction dispatcher: fetch, decode, issue to Conv/Add/Remap units.
// Optional illegal-opcode trap state enabled by macro ID_OPCODE_CHECK_EN.
module ins_dispatch #(
  parameter int          INS_W  = 512,
  parameter int unsigned SERIAL = 1,
  parameter int          CNT_W  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [INS_W-1:0] ins,
  input  logic             ins_valid,
  output logic             ins_ready,
  output logic             conv_valid,
  output logic             add_valid,
  output logic             remap_valid,
  input  logic             conv_ready,
  input  logic             add_ready,
  input  logic             remap_ready,
  output logic [INS_W-1:0] unit_ins,
  input  logic             conv_done,
  input  logic             add_done,
  input  logic             remap_done,
  output logic             halted,
  output logic             err,
  output logic [CNT_W-1:0] ins_cnt
);

  localparam logic [7:0] OP_NOP   = 8'h00;
  localparam logic [7:0] OP_CONV  = 8'h01;
  localparam logic [7:0] OP_ADD   = 8'h02;
  localparam logic [7:0] OP_REMAP = 8'h03;
  localparam logic [7:0] OP_END   = 8'h04;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_HALT  = 3'd3
`ifdef ID_OPCODE_CHECK_EN
    ,
    S_ERR   = 3'd4
`endif
  } state_t;

  state_t           state_q, state_d;
  logic [INS_W-1:0] unit_ins_q, unit_ins_d;
  logic [CNT_W-1:0] ins_cnt_q, ins_cnt_d;

  logic [7:0] op_q;
  logic       sel_ready, sel_done, accept, handshake;

  // The latched word carries its own opcode, so unit selection needs no extra register.
  assign op_q      = unit_ins_q[7:0];
  assign sel_ready = ((op_q == OP_CONV)  && conv_ready)
                   | ((op_q == OP_ADD)   && add_ready)
                   | ((op_q == OP_REMAP) && remap_ready);
  assign sel_done  = ((op_q == OP_CONV)  && conv_done)
                   | ((op_q == OP_ADD)   && add_done)
                   | ((op_q == OP_REMAP) && remap_done);
  assign accept    = (state_q == S_IDLE) && ins_valid;
  assign handshake = (state_q == S_ISSUE) && sel_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      unit_ins_q <= '0;
      ins_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      unit_ins_q <= unit_ins_d;
      ins_cnt_q  <= ins_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    unit_ins_d = accept ? ins : unit_ins_q;
    ins_cnt_d  = handshake ? ins_cnt_q + CNT_W'(1) : ins_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (ins_valid) begin
          case (ins[7:0])
            OP_CONV, OP_ADD, OP_REMAP: state_d = S_ISSUE;
            OP_END:                    state_d = S_HALT;
            OP_NOP:                    state_d = S_IDLE;
`ifdef ID_OPCODE_CHECK_EN
            default:                   state_d = S_ERR;
`else
            default:                   state_d = S_IDLE;
`endif
          endcase
        end
      end
      S_ISSUE: begin
        if (sel_ready) state_d = (SERIAL != 0) ? S_WAIT : S_IDLE;
      end
      S_WAIT: begin
        if (sel_done) state_d = S_IDLE;
      end
      default: state_d = state_q;
    endcase
  end

  always_comb begin
    ins_ready   = (state_q == S_IDLE);
    conv_valid  = (state_q == S_ISSUE) && (op_q == OP_CONV);
    add_valid   = (state_q == S_ISSUE) && (op_q == OP_ADD);
    remap_valid = (state_q == S_ISSUE) && (op_q == OP_REMAP);
    halted      = (state_q == S_HALT);
`ifdef ID_OPCODE_CHECK_EN
    err         = (state_q == S_ERR);
`else
    err         = 1'b0;
`endif
  end

  assign unit_ins = unit_ins_q;
  assign ins_cnt  = ins_cnt_q;

endmodule

// File: tb/tb_ins_dispatch.sv
// tb/tb_ins_dispatch.sv - randomized self-checking bench for ins_dispatch, SERIAL=1 and SERIAL=0 instances.
module tb_ins_dispatch;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [511:0] ins1, ui1, ins0, ui0;
  logic iv1, ir1, cv1, av1, rv1, cr1, ar1, rr1, cd1, ad1, rd1, h1, e1;
  logic iv0, ir0, cv0, av0, rv0, cr0, ar0, rr0, cd0, ad0, rd0, h0, e0;
  logic [31:0] cnt1;
  logic [3:0]  cnt0;

  ins_dispatch #(.INS_W(512), .SERIAL(1), .CNT_W(32)) dut1 (
    .clk(clk), .rst(rst), .ins(ins1), .ins_valid(iv1), .ins_ready(ir1),
    .conv_valid(cv1), .add_valid(av1), .remap_valid(rv1),
    .conv_ready(cr1), .add_ready(ar1), .remap_ready(rr1), .unit_ins(ui1),
    .conv_done(cd1), .add_done(ad1), .remap_done(rd1),
    .halted(h1), .err(e1), .ins_cnt(cnt1));

  ins_dispatch #(.INS_W(512), .SERIAL(0), .CNT_W(4)) dut0 (
    .clk(clk), .rst(rst), .ins(ins0), .ins_valid(iv0), .ins_ready(ir0),
    .conv_valid(cv0), .add_valid(av0), .remap_valid(rv0),
    .conv_ready(cr0), .add_ready(ar0), .remap_ready(rr0), .unit_ins(ui0),
    .conv_done(cd0), .add_done(ad0), .remap_done(rd0),
    .halted(h0), .err(e0), .ins_cnt(cnt0));

  int tests = 0;
  int fails = 0;
  longint exp_cnt1 = 0;
  int     exp_cnt0 = 0;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] rnd_word(input logic [7:0] op);
    logic [511:0] w;
    for (int i = 0; i < 16; i++) w[i*32 +: 32] = $urandom;
    w[7:0] = op;
    return w;
  endfunction

  // Expected one-hot {remap,add,conv} for an opcode; zero for anything that is not a unit op.
  function automatic logic [2:0] onehot(input logic [7:0] op);
    case (op)
      8'h01:   return 3'b001;
      8'h02:   return 3'b010;
      8'h03:   return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [7:0] rnd_op();
    int r;
    r = $urandom_range(0, 4);
    if (r < 4) return 8'(r);
`ifdef ID_OPCODE_CHECK_EN
    return 8'h00;
`else
    return 8'($urandom_range(5, 255));
`endif
  endfunction

  task automatic set_rdy1(input logic [2:0] own, input logic [2:0] v);
    {rr1, ar1, cr1} = (own & v) | (~own & 3'($urandom));
  endtask

  // Serial instance: accept, wait rd_dly cycles for ready, then wait dn_dly cycles before done.
  task automatic issue1(input logic [7:0] op, input int rd_dly, input int dn_dly, input logic hs_done);
    logic [511:0] w;
    logic [2:0] oh;
    w = rnd_word(op);
    oh = onehot(op);
    chk("s1_idle_ready", 512'(ir1), 512'(1));
    ins1 = w; iv1 = 1'b1;
    @(negedge clk);
    iv1 = 1'b0; ins1 = rnd_word(8'h01);
    chk("s1_unit_ins_latched", ui1, w);
    if (oh != 3'b000) begin
      for (int k = 0; k < rd_dly; k++) begin
        chk("s1_valid_hold", 512'({rv1, av1, cv1}), 512'(oh));
        chk("s1_ins_hold", ui1, w);
        chk("s1_busy", 512'(ir1), 512'(0));
        set_rdy1(oh, 3'b000);
        @(negedge clk);
      end
      chk("s1_valid_hs", 512'({rv1, av1, cv1}), 512'(oh));
      set_rdy1(oh, 3'b111);
      {rd1, ad1, cd1} = hs_done ? oh : 3'b000;
      @(negedge clk);
      exp_cnt1++;
      {rr1, ar1, cr1} = 3'b000; {rd1, ad1, cd1} = 3'b000;
      chk("s1_cnt", 512'(cnt1), 512'(exp_cnt1[31:0]));
      chk("s1_valid_drop", 512'({rv1, av1, cv1}), 512'(0));
      chk("s1_wait_busy", 512'(ir1), 512'(0));
      for (int k = 0; k < dn_dly; k++) begin
        {rd1, ad1, cd1} = ~oh & 3'($urandom);
        @(negedge clk);
        chk("s1_wait_hold", 512'(ir1), 512'(0));
      end
      {rd1, ad1, cd1} = oh;
      @(negedge clk);
      {rd1, ad1, cd1} = 3'b000;
      chk("s1_done_ready", 512'(ir1), 512'(1));
      chk("s1_ins_after", ui1, w);
    end else begin
      chk("s1_nop_valid", 512'({rv1, av1, cv1}), 512'(0));
      chk("s1_nop_ready", 512'(ir1), 512'(1));
      chk("s1_nop_cnt", 512'(cnt1), 512'(exp_cnt1[31:0]));
    end
  endtask

  // Pipelined instance: returns to accepting right after the handshake; counter wraps at 16.
  task automatic issue0(input logic [7:0] op, input int rd_dly);
    logic [511:0] w;
    logic [2:0] oh;
    w = rnd_word(op);
    oh = onehot(op);
    chk("s0_idle_ready", 512'(ir0), 512'(1));
    ins0 = w; iv0 = 1'b1;
    @(negedge clk);
    iv0 = 1'b0;
    chk("s0_unit_ins_latched", ui0, w);
    if (oh != 3'b000) begin
      for (int k = 0; k < rd_dly; k++) begin
        chk("s0_valid_hold", 512'({rv0, av0, cv0}), 512'(oh));
        {rr0, ar0, cr0} = ~oh & 3'($urandom);
        @(negedge clk);
      end
      chk("s0_valid_hs", 512'({rv0, av0, cv0}), 512'(oh));
      {rr0, ar0, cr0} = oh;
      @(negedge clk);
      {rr0, ar0, cr0} = 3'b000;
      exp_cnt0 = (exp_cnt0 + 1) % 16;
      chk("s0_cnt", 512'(cnt0), 512'(exp_cnt0));
      chk("s0_no_wait", 512'(ir0), 512'(1));
      chk("s0_valid_drop", 512'({rv0, av0, cv0}), 512'(0));
    end else begin
      chk("s0_nop_ready", 512'(ir0), 512'(1));
      chk("s0_nop_valid", 512'({rv0, av0, cv0}), 512'(0));
      chk("s0_nop_cnt", 512'(cnt0), 512'(exp_cnt0));
    end
  endtask

  task automatic chk_reset1(input string tag);
    chk({tag, "_ready"}, 512'(ir1), 512'(1));
    chk({tag, "_valids"}, 512'({rv1, av1, cv1}), 512'(0));
    chk({tag, "_unit_ins"}, ui1, 512'(0));
    chk({tag, "_halted"}, 512'(h1), 512'(0));
    chk({tag, "_err"}, 512'(e1), 512'(0));
    chk({tag, "_cnt"}, 512'(cnt1), 512'(0));
  endtask

  initial begin
    logic [511:0] w;
    ins1 = '0; iv1 = 0; cr1 = 0; ar1 = 0; rr1 = 0; cd1 = 0; ad1 = 0; rd1 = 0;
    ins0 = '0; iv0 = 0; cr0 = 0; ar0 = 0; rr0 = 0; cd0 = 0; ad0 = 0; rd0 = 0;
    #3;
    chk_reset1("rst1");
    chk("rst0_cnt", 512'(cnt0), 512'(0));
    chk("rst0_err", 512'(e0), 512'(0));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    issue1(8'h01, 0, 3, 1'b0);
    issue1(8'h02, 5, 2, 1'b1);
    issue1(8'h00, 0, 0, 1'b0);
    for (int i = 0; i < 30; i++)
      issue1(rnd_op(), $urandom_range(0, 4), $urandom_range(0, 3), 1'($urandom));

    issue0(8'h03, 0);
    issue0(8'h03, 0);
    issue0(8'h00, 0);
    for (int i = 0; i < 20; i++)
      issue0(8'($urandom_range(1, 3)), $urandom_range(0, 2));

`ifdef ID_OPCODE_CHECK_EN
    ins0 = rnd_word(8'h7F); iv0 = 1'b1;
    @(negedge clk);
    ins0 = rnd_word(8'h01);
    for (int k = 0; k < 4; k++) begin
      chk("err_flag", 512'(e0), 512'(1));
      chk("err_ready", 512'(ir0), 512'(0));
      chk("err_noissue", 512'({rv0, av0, cv0}), 512'(0));
      chk("err_not_halted", 512'(h0), 512'(0));
      @(negedge clk);
    end
    iv0 = 1'b0;
`else
    issue0(8'h7F, 0);
    chk("illegal_err", 512'(e0), 512'(0));
    issue0(8'h01, 1);
`endif

    w = rnd_word(8'h04);
    ins1 = w; iv1 = 1'b1;
    @(negedge clk);
    ins1 = rnd_word(8'h01);
    cr1 = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk("halt_flag", 512'(h1), 512'(1));
      chk("halt_ready", 512'(ir1), 512'(0));
      chk("halt_noconv", 512'({rv1, av1, cv1}), 512'(0));
      chk("halt_ins", ui1, w);
      chk("halt_cnt", 512'(cnt1), 512'(exp_cnt1[31:0]));
      @(negedge clk);
    end
    iv1 = 1'b0; cr1 = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_cnt1 = 0; exp_cnt0 = 0;
    chk_reset1("post_halt");
    chk("post_rst0_ready", 512'(ir0), 512'(1));
    chk("post_rst0_err", 512'(e0), 512'(0));

    ins1 = rnd_word(8'h01); iv1 = 1'b1;
    @(negedge clk);
    iv1 = 1'b0; cr1 = 1'b1;
    @(negedge clk);
    cr1 = 1'b0;
    chk("midwait_cnt", 512'(cnt1), 512'(1));
    chk("midwait_busy", 512'(ir1), 512'(0));
    #2 rst = 1'b1;
    #1 chk_reset1("async_rst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("after_rst_ready", 512'(ir1), 512'(1));
    chk("after_rst_noissue", 512'({rv1, av1, cv1}), 512'(0));
    issue1(8'h03, 1, 1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
